// File: rtl/scr1_tcm_portb_arb.sv
// Port B arbiter for the TCM dual-port RAM.
// Requester 0 (core data) has fixed priority; requester 1 (debug/DMA loader)
// is guaranteed progress by a starvation counter. Read data is steered back
// to the requester that issued the read, one cycle after its grant.
module scr1_tcm_portb_arb #(
  parameter int SCR1_WIDTH   = 32,
  parameter int SCR1_SIZE    = 32'h00010000,
  parameter int SCR1_NBYTES  = SCR1_WIDTH / 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // requester 0
  input  logic                           m0_req,
  input  logic                           m0_we,
  input  logic [$clog2(SCR1_SIZE)-3:0]   m0_addr,
  input  logic [SCR1_NBYTES-1:0]         m0_be,
  input  logic [SCR1_WIDTH-1:0]          m0_wdata,
  output logic                           m0_ack,
  output logic                           m0_rvalid,
  output logic [SCR1_WIDTH-1:0]          m0_rdata,
  // requester 1
  input  logic                           m1_req,
  input  logic                           m1_we,
  input  logic [$clog2(SCR1_SIZE)-3:0]   m1_addr,
  input  logic [SCR1_NBYTES-1:0]         m1_be,
  input  logic [SCR1_WIDTH-1:0]          m1_wdata,
  output logic                           m1_ack,
  output logic                           m1_rvalid,
  output logic [SCR1_WIDTH-1:0]          m1_rdata,
  // RAM port B
  output logic                           renb,
  output logic                           wenb,
  output logic [SCR1_NBYTES-1:0]         webb,
  output logic [$clog2(SCR1_SIZE)-3:0]   addrb,
  output logic [SCR1_WIDTH-1:0]          datab,
  input  logic [SCR1_WIDTH-1:0]          qb
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       gnt0;
  logic       gnt1;
  logic       sel1;
  logic       g_we;
  logic [SCR1_NBYTES-1:0] g_be;
  logic [3:0] starve_cnt_reg;
  logic       rd_pend_reg;
  logic       rd_owner_reg;

  // Grant decision: m1 wins when alone or when it has waited STARVE_LIMIT cycles
  always_comb begin
    sel1 = m1_req & (~m0_req | (starve_cnt_reg == LIMIT));
    gnt1 = rst_n & sel1;
    gnt0 = rst_n & m0_req & ~sel1;
  end

  // Drive port B from the winner; with no grant the m0 fields pass through
  always_comb begin
    addrb = gnt1 ? m1_addr  : m0_addr;
    datab = gnt1 ? m1_wdata : m0_wdata;
    g_we  = gnt1 ? m1_we    : m0_we;
    g_be  = gnt1 ? m1_be    : m0_be;
    wenb  = (gnt0 | gnt1) & g_we;
    renb  = (gnt0 | gnt1) & ~g_we;
    webb  = wenb ? g_be : '0;
  end

  // Starvation counter and read-response tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
      rd_pend_reg    <= 1'b0;
      rd_owner_reg   <= 1'b0;
    end else begin
      if (m1_req && !gnt1) begin
        starve_cnt_reg <= (starve_cnt_reg == LIMIT) ? LIMIT : starve_cnt_reg + 4'd1;
      end else begin
        starve_cnt_reg <= '0;
      end
      rd_pend_reg <= renb;
      if (renb) begin
        rd_owner_reg <= gnt1;
      end
    end
  end

  assign m0_ack    = gnt0;
  assign m1_ack    = gnt1;
  assign m0_rvalid = rd_pend_reg & ~rd_owner_reg;
  assign m1_rvalid = rd_pend_reg &  rd_owner_reg;
  // Both requesters see the RAM output; rvalid tells each whether it is theirs
  assign m0_rdata  = qb;
  assign m1_rdata  = qb;

endmodule
